// File: rtl/cache_defs.sv
// Shared definitions for the victim cache.
//   vc_state_e        : controller state (IDLE, WB, FLUSH)
//   DCACHE_LINE_WIDTH : default line data width in bits
//   VICTIM_ADDR_BITS  : default line address (tag+index) width
package cache_defs;

  localparam int DCACHE_LINE_WIDTH = 32;
  localparam int VICTIM_ADDR_BITS  = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FLUSH = 2'd2
  } vc_state_e;

endpackage

// File: rtl/victim_cache_repl.sv
// LRU age tracker for the victim cache.
// Each entry holds an age; 0 is most recent, NUM_ENTRIES-1 is the victim.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset (age[i] = i)
//   touch0_i / touch0_idx_i  : first access this cycle (lookup hit)
//   touch1_i / touch1_idx_i  : second access this cycle (insert), applied after touch0
//   victim_idx_o             : index of the entry whose age is NUM_ENTRIES-1
module victim_cache_repl #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           touch0_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] touch0_idx_i,
  input  logic                           touch1_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] touch1_idx_i,
  output logic [$clog2(NUM_ENTRIES)-1:0] victim_idx_o
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam logic [IW-1:0] OLDEST = IW'(NUM_ENTRIES - 1);

  typedef logic [NUM_ENTRIES-1:0][IW-1:0] ages_t;

  ages_t age_q, age_d;

  // Entries younger than the touched one age by one; ages stay a permutation.
  function automatic ages_t apply_touch(input ages_t a, input logic [IW-1:0] t);
    ages_t r;
    r = a;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (a[i] < a[t]) r[i] = a[i] + 1'b1;
    end
    r[t] = '0;
    return r;
  endfunction

  always_comb begin
    age_d = age_q;
    if (touch0_i) age_d = apply_touch(age_d, touch0_idx_i);
    if (touch1_i) age_d = apply_touch(age_d, touch1_idx_i);
  end

  always_comb begin
    victim_idx_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (age_q[i] == OLDEST) victim_idx_o = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= IW'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/victim_cache_nway.sv
// Fully-associative victim cache with FIFO or LRU replacement, dirty-line
// writeback and a flush sequencer.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   flush_i            : flush request pulse; flush_done_o pulses when complete
//   ins_*              : insert channel (ins_ready_o high only in IDLE)
//   lkp_*              : combinational lookup; lkp_take_i invalidates a hit entry
//   wb_*               : writeback channel, valid/ready handshake
module victim_cache_nway
  import cache_defs::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int LINE_WIDTH  = DCACHE_LINE_WIDTH,
  parameter int ADDR_BITS   = VICTIM_ADDR_BITS,
  parameter int REPL_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ins_valid_i,
  output logic                  ins_ready_o,
  input  logic [ADDR_BITS-1:0]  ins_addr_i,
  input  logic [LINE_WIDTH-1:0] ins_data_i,
  input  logic                  ins_dirty_i,
  input  logic                  lkp_valid_i,
  input  logic                  lkp_take_i,
  input  logic [ADDR_BITS-1:0]  lkp_addr_i,
  output logic                  lkp_hit_o,
  output logic [LINE_WIDTH-1:0] lkp_data_o,
  output logic                  lkp_dirty_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [ADDR_BITS-1:0]  wb_addr_o,
  output logic [LINE_WIDTH-1:0] wb_data_o,
  output logic                  flush_done_o
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [ADDR_BITS-1:0]   addr_q [NUM_ENTRIES];
  logic [ADDR_BITS-1:0]   addr_d [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]  data_q [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]  data_d [NUM_ENTRIES];
  logic [IW-1:0]          fifo_ptr_q, fifo_ptr_d, flush_idx_q, flush_idx_d;
  vc_state_e              state_q, state_d;
  logic                   flush_pend_q, flush_pend_d, flush_done_q, flush_done_d;
  logic [ADDR_BITS-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE_WIDTH-1:0]  wb_data_q, wb_data_d;

  logic          hit_any, ins_hit_any, free_any, ins_acc, replace;
  logic [IW-1:0] hit_idx, ins_hit_idx, free_idx, victim_idx, ins_idx, lru_victim;
  logic          flush_cur_dirty;

  // Address match search for lookup and insert, plus lowest free slot.
  always_comb begin
    hit_any     = 1'b0;
    hit_idx     = '0;
    ins_hit_any = 1'b0;
    ins_hit_idx = '0;
    free_any    = 1'b0;
    free_idx    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && addr_q[i] == lkp_addr_i) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (valid_q[i] && addr_q[i] == ins_addr_i) begin
        ins_hit_any = 1'b1;
        ins_hit_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign lkp_hit_o   = lkp_valid_i & hit_any & (state_q != FLUSH) & ~rst;
  assign lkp_data_o  = lkp_hit_o ? data_q[hit_idx] : '0;
  assign lkp_dirty_o = lkp_hit_o & dirty_q[hit_idx];

  assign ins_ready_o = (state_q == IDLE);
  assign ins_acc     = ins_valid_i & ins_ready_o & ~rst;
  assign replace     = ~ins_hit_any & ~free_any;
  assign victim_idx  = (REPL_MODE == 1) ? lru_victim : fifo_ptr_q;
  assign ins_idx     = ins_hit_any ? ins_hit_idx : (free_any ? free_idx : victim_idx);

  if (REPL_MODE == 1) begin : g_lru
    victim_cache_repl #(
      .NUM_ENTRIES (NUM_ENTRIES)
    ) u_repl (
      .clk          (clk),
      .rst          (rst),
      .touch0_i     (lkp_hit_o),
      .touch0_idx_i (hit_idx),
      .touch1_i     (ins_acc),
      .touch1_idx_i (ins_idx),
      .victim_idx_o (lru_victim)
    );
  end else begin : g_fifo
    assign lru_victim = '0;
  end

  // During FLUSH the scanned entry drives the writeback port directly; the
  // entry cannot change under it because inserts and hits are blocked.
  assign flush_cur_dirty = valid_q[flush_idx_q] & dirty_q[flush_idx_q];
  assign wb_valid_o   = ~rst & ((state_q == WB) | ((state_q == FLUSH) & flush_cur_dirty));
  assign wb_addr_o    = (state_q == FLUSH) ? addr_q[flush_idx_q] : wb_addr_q;
  assign wb_data_o    = (state_q == FLUSH) ? data_q[flush_idx_q] : wb_data_q;
  assign flush_done_o = flush_done_q & ~rst;

  always_comb begin
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    addr_d       = addr_q;
    data_d       = data_q;
    fifo_ptr_d   = fifo_ptr_q;
    flush_idx_d  = flush_idx_q;
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;

    if (lkp_hit_o && lkp_take_i) begin
      valid_d[hit_idx] = 1'b0;
      dirty_d[hit_idx] = 1'b0;
    end

    // Applied after the take so a same-address insert keeps the entry valid.
    if (ins_acc) begin
      valid_d[ins_idx] = 1'b1;
      addr_d[ins_idx]  = ins_addr_i;
      data_d[ins_idx]  = ins_data_i;
      dirty_d[ins_idx] = ins_hit_any ? (dirty_q[ins_idx] | ins_dirty_i) : ins_dirty_i;
      if (replace) begin
        fifo_ptr_d = fifo_ptr_q + 1'b1;
        wb_addr_d  = addr_q[victim_idx];
        wb_data_d  = data_q[victim_idx];
      end
    end

    case (state_q)
      IDLE: begin
        if (ins_acc && replace && dirty_q[victim_idx]) begin
          state_d      = WB;
          flush_pend_d = flush_i;
        end else if (flush_i) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      WB: begin
        if (wb_ready_i) begin
          state_d      = (flush_pend_q || flush_i) ? FLUSH : IDLE;
          flush_pend_d = 1'b0;
          flush_idx_d  = '0;
        end else if (flush_i) begin
          flush_pend_d = 1'b1;
        end
      end
      FLUSH: begin
        if (!flush_cur_dirty || wb_ready_i) begin
          valid_d[flush_idx_q] = 1'b0;
          dirty_d[flush_idx_q] = 1'b0;
          if (flush_idx_q == LAST_IDX) begin
            state_d      = IDLE;
            flush_done_d = 1'b1;
          end else begin
            flush_idx_d = flush_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    data_q    <= data_d;
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
    if (rst) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      fifo_ptr_q   <= '0;
      flush_idx_q  <= '0;
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      fifo_ptr_q   <= fifo_ptr_d;
      flush_idx_q  <= flush_idx_d;
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_victim_cache_nway.sv
// Directed bench for victim_cache_nway: one FIFO instance and one LRU
// instance share all inputs; each scenario task checks its own outputs.
module tb_victim_cache_nway;
  import cache_defs::*;

  localparam int AW = VICTIM_ADDR_BITS;
  localparam int LW = DCACHE_LINE_WIDTH;

  logic          clk = 1'b0;
  logic          rst, flush_i, ins_valid, ins_dirty, lkp_valid, lkp_take, wb_ready;
  logic [AW-1:0] ins_addr, lkp_addr;
  logic [LW-1:0] ins_data;

  logic          f_ins_ready, f_lkp_hit, f_lkp_dirty, f_wb_valid, f_flush_done;
  logic [LW-1:0] f_lkp_data, f_wb_data;
  logic [AW-1:0] f_wb_addr;
  logic          l_ins_ready, l_lkp_hit, l_lkp_dirty, l_wb_valid, l_flush_done;
  logic [LW-1:0] l_lkp_data, l_wb_data;
  logic [AW-1:0] l_wb_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  victim_cache_nway #(.NUM_ENTRIES(4), .REPL_MODE(0)) u_fifo (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ins_valid_i(ins_valid), .ins_ready_o(f_ins_ready), .ins_addr_i(ins_addr),
    .ins_data_i(ins_data), .ins_dirty_i(ins_dirty),
    .lkp_valid_i(lkp_valid), .lkp_take_i(lkp_take), .lkp_addr_i(lkp_addr),
    .lkp_hit_o(f_lkp_hit), .lkp_data_o(f_lkp_data), .lkp_dirty_o(f_lkp_dirty),
    .wb_valid_o(f_wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(f_wb_addr),
    .wb_data_o(f_wb_data), .flush_done_o(f_flush_done)
  );

  victim_cache_nway #(.NUM_ENTRIES(4), .REPL_MODE(1)) u_lru (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ins_valid_i(ins_valid), .ins_ready_o(l_ins_ready), .ins_addr_i(ins_addr),
    .ins_data_i(ins_data), .ins_dirty_i(ins_dirty),
    .lkp_valid_i(lkp_valid), .lkp_take_i(lkp_take), .lkp_addr_i(lkp_addr),
    .lkp_hit_o(l_lkp_hit), .lkp_data_o(l_lkp_data), .lkp_dirty_o(l_lkp_dirty),
    .wb_valid_o(l_wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(l_wb_addr),
    .wb_data_o(l_wb_data), .flush_done_o(l_flush_done)
  );

  function automatic logic [LW-1:0] dat(input int a);
    return LW'(32'hDA7A_0000) + LW'(a);
  endfunction

  task automatic clr_inputs();
    flush_i = 1'b0; ins_valid = 1'b0; ins_addr = '0; ins_data = '0; ins_dirty = 1'b0;
    lkp_valid = 1'b0; lkp_take = 1'b0; lkp_addr = '0; wb_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic insert(input int a, input logic [LW-1:0] d, input logic dty);
    @(negedge clk);
    ins_valid = 1'b1; ins_addr = AW'(a); ins_data = d; ins_dirty = dty;
    @(negedge clk);
    ins_valid = 1'b0; ins_dirty = 1'b0;
  endtask

  // Raises a plain lookup mid-cycle; caller compares, then drops lkp_valid.
  task automatic probe(input int a);
    @(negedge clk);
    lkp_valid = 1'b1; lkp_take = 1'b0; lkp_addr = AW'(a);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); clr_inputs(); rst = 1'b1; lkp_valid = 1'b1; lkp_addr = AW'(16);
    @(negedge clk); #1;
    n_checks++; if (f_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", f_wb_valid); end
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lkp_hit: got %0b want 0", f_lkp_hit); end
    n_checks++; if (f_flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %0b want 0", f_flush_done); end
    rst = 1'b0; lkp_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (f_ins_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ins_ready_fifo: got %0b want 1", f_ins_ready); end
    n_checks++; if (l_ins_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ins_ready_lru: got %0b want 1", l_ins_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) insert(16 + i, dat(16 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      probe(16 + i);
      n_checks++; if (f_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL fill_hit[%0d]: got %0b want 1", i, f_lkp_hit); end
      n_checks++; if (f_lkp_data !== dat(16 + i)) begin n_fail++; $display("FAIL fill_data[%0d]: got %h want %h", i, f_lkp_data, dat(16 + i)); end
      n_checks++; if (f_lkp_dirty !== 1'b0) begin n_fail++; $display("FAIL fill_dirty[%0d]: got %0b want 0", i, f_lkp_dirty); end
      lkp_valid = 1'b0;
    end
    probe(20);
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL fill_miss_hit: got %0b want 0", f_lkp_hit); end
    n_checks++; if (f_lkp_data !== '0) begin n_fail++; $display("FAIL fill_miss_data: got %h want 0", f_lkp_data); end
    lkp_valid = 1'b0;
    insert(20, dat(20), 1'b0);
    n_checks++; if (f_wb_valid !== 1'b0) begin n_fail++; $display("FAIL fill_clean_evict_wb: got %0b want 0", f_wb_valid); end
    n_checks++; if (f_ins_ready !== 1'b1) begin n_fail++; $display("FAIL fill_clean_evict_ready: got %0b want 1", f_ins_ready); end
    probe(16);
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL fill_evicted_0x10: got %0b want 0", f_lkp_hit); end
    lkp_valid = 1'b0;
    probe(20);
    n_checks++; if (f_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL fill_new_0x14: got %0b want 1", f_lkp_hit); end
    lkp_valid = 1'b0;
    // Pointer now at 1: the next replacement must take 0x11.
    insert(21, dat(21), 1'b0);
    probe(17);
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL fill_ptr1_evict_0x11: got %0b want 0", f_lkp_hit); end
    lkp_valid = 1'b0;
    probe(18);
    n_checks++; if (f_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL fill_ptr1_keep_0x12: got %0b want 1", f_lkp_hit); end
    lkp_valid = 1'b0;
  endtask

  task automatic test_dirty_wb();
    do_reset();
    insert(16, 32'hA0A0_0010, 1'b1);
    for (int i = 1; i < 4; i++) insert(16 + i, dat(16 + i), 1'b0);
    insert(20, dat(20), 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (f_wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid[%0d]: got %0b want 1", k, f_wb_valid); end
      n_checks++; if (f_wb_addr !== AW'(16)) begin n_fail++; $display("FAIL wb_addr[%0d]: got %h want 10", k, f_wb_addr); end
      n_checks++; if (f_wb_data !== 32'hA0A0_0010) begin n_fail++; $display("FAIL wb_data[%0d]: got %h want a0a00010", k, f_wb_data); end
      n_checks++; if (f_ins_ready !== 1'b0) begin n_fail++; $display("FAIL wb_ins_ready[%0d]: got %0b want 0", k, f_ins_ready); end
      if (k == 3) wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
    end
    #1;
    n_checks++; if (f_wb_valid !== 1'b0) begin n_fail++; $display("FAIL wb_done_valid: got %0b want 0", f_wb_valid); end
    n_checks++; if (f_ins_ready !== 1'b1) begin n_fail++; $display("FAIL wb_done_ready: got %0b want 1", f_ins_ready); end
    probe(20);
    n_checks++; if (f_lkp_hit !== 1'b1 || f_lkp_data !== dat(20)) begin n_fail++; $display("FAIL wb_new_line: hit %0b data %h want 1 %h", f_lkp_hit, f_lkp_data, dat(20)); end
    lkp_valid = 1'b0;
  endtask

  task automatic test_lru();
    do_reset();
    for (int i = 0; i < 4; i++) insert(16 + i, dat(16 + i), 1'b0);
    @(negedge clk); lkp_valid = 1'b1; lkp_addr = AW'(16); #1;
    n_checks++; if (l_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL lru_touch_hit: got %0b want 1", l_lkp_hit); end
    @(negedge clk); lkp_valid = 1'b0;
    insert(32, dat(32), 1'b0);
    probe(17);
    n_checks++; if (l_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL lru_evict_0x11: got %0b want 0", l_lkp_hit); end
    n_checks++; if (f_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL fifo_keep_0x11: got %0b want 1", f_lkp_hit); end
    lkp_valid = 1'b0;
    probe(16);
    n_checks++; if (l_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL lru_keep_0x10: got %0b want 1", l_lkp_hit); end
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL fifo_evict_0x10: got %0b want 0", f_lkp_hit); end
    lkp_valid = 1'b0;
    probe(32);
    n_checks++; if (l_lkp_hit !== 1'b1 || l_lkp_data !== dat(32)) begin n_fail++; $display("FAIL lru_new_0x20: hit %0b data %h want 1 %h", l_lkp_hit, l_lkp_data, dat(32)); end
    lkp_valid = 1'b0;
  endtask

  task automatic test_take();
    do_reset();
    insert(16, dat(16), 1'b0);
    insert(17, dat(17), 1'b0);
    insert(18, dat(18), 1'b1);
    insert(19, dat(19), 1'b0);
    @(negedge clk); lkp_valid = 1'b1; lkp_take = 1'b1; lkp_addr = AW'(18); #1;
    n_checks++; if (f_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL take_hit: got %0b want 1", f_lkp_hit); end
    n_checks++; if (f_lkp_data !== dat(18)) begin n_fail++; $display("FAIL take_data: got %h want %h", f_lkp_data, dat(18)); end
    n_checks++; if (f_lkp_dirty !== 1'b1) begin n_fail++; $display("FAIL take_dirty: got %0b want 1", f_lkp_dirty); end
    @(negedge clk); lkp_valid = 1'b0; lkp_take = 1'b0;
    probe(18);
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL take_then_miss: got %0b want 0", f_lkp_hit); end
    lkp_valid = 1'b0;
    insert(48, dat(48), 1'b0);
    n_checks++; if (f_wb_valid !== 1'b0) begin n_fail++; $display("FAIL take_reuse_wb: got %0b want 0", f_wb_valid); end
    for (int i = 0; i < 4; i++) begin
      int a;
      a = (i == 2) ? 48 : 16 + i;
      probe(a);
      n_checks++; if (f_lkp_hit !== 1'b1) begin n_fail++; $display("FAIL take_reuse_hit[%h]: got %0b want 1", a, f_lkp_hit); end
      lkp_valid = 1'b0;
    end
  endtask

  task automatic test_update();
    do_reset();
    insert(64, 32'h1111_1111, 1'b1);
    insert(64, 32'h2222_2222, 1'b0);
    probe(64);
    n_checks++; if (f_lkp_data !== 32'h2222_2222) begin n_fail++; $display("FAIL update_data: got %h want 22222222", f_lkp_data); end
    n_checks++; if (f_lkp_dirty !== 1'b1) begin n_fail++; $display("FAIL update_dirty_or: got %0b want 1", f_lkp_dirty); end
    lkp_valid = 1'b0;
    @(negedge clk);
    lkp_valid = 1'b1; lkp_take = 1'b1; lkp_addr = AW'(64);
    ins_valid = 1'b1; ins_addr = AW'(64); ins_data = 32'h3333_3333; ins_dirty = 1'b0;
    @(negedge clk);
    lkp_valid = 1'b0; lkp_take = 1'b0; ins_valid = 1'b0;
    probe(64);
    n_checks++; if (f_lkp_hit !== 1'b1 || f_lkp_data !== 32'h3333_3333) begin n_fail++; $display("FAIL take_insert_race: hit %0b data %h want 1 33333333", f_lkp_hit, f_lkp_data); end
    lkp_valid = 1'b0;
  endtask

  task automatic test_flush();
    int            n_xfer = 0;
    int            n_done = 0;
    logic [AW-1:0] xa [2];
    logic [LW-1:0] xd [2];
    do_reset();
    for (int i = 0; i < 4; i++) insert(16 + i, dat(16 + i), (i == 1 || i == 3));
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      wb_ready = (c % 3 == 2);
      #1;
      if (f_wb_valid && wb_ready) begin
        if (n_xfer < 2) begin xa[n_xfer] = f_wb_addr; xd[n_xfer] = f_wb_data; end
        n_xfer++;
      end
      if (f_flush_done) n_done++;
      @(negedge clk);
    end
    wb_ready = 1'b0;
    n_checks++; if (n_xfer !== 2) begin n_fail++; $display("FAIL flush_xfer_count: got %0d want 2", n_xfer); end
    if (n_xfer >= 2) begin
      n_checks++; if (xa[0] !== AW'(17) || xd[0] !== dat(17)) begin n_fail++; $display("FAIL flush_xfer0: got %h/%h want 11/%h", xa[0], xd[0], dat(17)); end
      n_checks++; if (xa[1] !== AW'(19) || xd[1] !== dat(19)) begin n_fail++; $display("FAIL flush_xfer1: got %h/%h want 13/%h", xa[1], xd[1], dat(19)); end
    end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL flush_done_cycles: got %0d want 1", n_done); end
    n_checks++; if (f_ins_ready !== 1'b1) begin n_fail++; $display("FAIL flush_back_idle: got %0b want 1", f_ins_ready); end
    for (int i = 0; i < 4; i++) begin
      probe(16 + i);
      n_checks++; if (f_lkp_hit !== 1'b0 || l_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL flush_miss[%0d]: got %0b/%0b want 0/0", i, f_lkp_hit, l_lkp_hit); end
      lkp_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_wb();
    do_reset();
    insert(16, dat(16), 1'b1);
    for (int i = 1; i < 4; i++) insert(16 + i, dat(16 + i), 1'b0);
    insert(20, dat(20), 1'b0);
    #1;
    n_checks++; if (f_wb_valid !== 1'b1) begin n_fail++; $display("FAIL midwb_in_wb: got %0b want 1", f_wb_valid); end
    @(negedge clk); rst = 1'b1; lkp_valid = 1'b1; lkp_addr = AW'(17); #1;
    n_checks++; if (f_wb_valid !== 1'b0) begin n_fail++; $display("FAIL midwb_during_rst_wb: got %0b want 0", f_wb_valid); end
    n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL midwb_during_rst_hit: got %0b want 0", f_lkp_hit); end
    @(negedge clk); rst = 1'b0; lkp_valid = 1'b0; #1;
    n_checks++; if (f_wb_valid !== 1'b0) begin n_fail++; $display("FAIL midwb_after_wb: got %0b want 0", f_wb_valid); end
    n_checks++; if (f_ins_ready !== 1'b1) begin n_fail++; $display("FAIL midwb_after_ready: got %0b want 1", f_ins_ready); end
    for (int i = 0; i < 5; i++) begin
      probe(16 + i);
      n_checks++; if (f_lkp_hit !== 1'b0) begin n_fail++; $display("FAIL midwb_miss[%0d]: got %0b want 0", i, f_lkp_hit); end
      lkp_valid = 1'b0;
    end
  endtask

  initial begin
    clr_inputs();
    rst = 1'b0;
    test_reset();
    test_fill();
    test_dirty_wb();
    test_lru();
    test_take();
    test_update();
    test_flush();
    test_reset_mid_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/victim_cache_nway.md
VICTIM_CACHE_NWAY -- requirements
Module: victim_cache_nway

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4: number of fully-associative entries, power of two, range 2..16.
REQ-002 SHALL have parameter LINE_WIDTH, default DCACHE_LINE_WIDTH: data bits per line.
REQ-003 SHALL have parameter ADDR_BITS, default VICTIM_ADDR_BITS: line address (tag+index) width.
REQ-004 SHALL have parameter REPL_MODE, default 0: replacement policy, 0 = FIFO, 1 = LRU.
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have the following ports:
- flush_i  input  1  flush request pulse.
- ins_valid_i  input  1  insert request.
- ins_ready_o  output  1  insert can be accepted.
- ins_addr_i  input  ADDR_BITS  insert line address.
- ins_data_i  input  LINE_WIDTH  insert line data.
- ins_dirty_i  input  1  inserted line is dirty.
- lkp_valid_i  input  1  lookup request.
- lkp_take_i  input  1  on hit, invalidate entry (swap back to dcache).
- lkp_addr_i  input  ADDR_BITS  lookup address.
- lkp_hit_o  output  1  lookup hit.
- lkp_data_o  output  LINE_WIDTH  hit data.
- lkp_dirty_o  output  1  hit entry dirty.
- wb_valid_o  output  1  writeback line valid.
- wb_ready_i  input  1  memory accepts writeback.
- wb_addr_o  output  ADDR_BITS  writeback address.
- wb_data_o  output  LINE_WIDTH  writeback data.
- flush_done_o  output  1  one-cycle flush completion pulse.

Function
REQ-007 The FSM SHALL have states IDLE, WB and FLUSH. ins_ready_o SHALL be 1 only in IDLE.
REQ-008 Lookup SHALL be combinational, zero latency.
- lkp_hit_o = lkp_valid_i & (a valid entry's address equals lkp_addr_i) & state != FLUSH.
- lkp_data_o and lkp_dirty_o SHALL be 0 on a miss.
REQ-009 On a hit with lkp_take_i=1, the entry's valid and dirty bits SHALL clear at the next edge.
REQ-010 On a hit with REPL_MODE=1, the hit entry SHALL become most-recently-used.
REQ-011 An accepted insert whose address matches a valid entry SHALL update that entry:
- data overwritten.
- dirty = old dirty | ins_dirty_i.
- entry made MRU when REPL_MODE=1.
REQ-012 Otherwise, an accepted insert SHALL allocate the lowest-index invalid entry.
REQ-013 When all entries are valid, the insert SHALL replace a victim:
- victim is the FIFO pointer entry (REPL_MODE=0) or the LRU entry (REPL_MODE=1).
- the FIFO pointer increments only on replacement and wraps NUM_ENTRIES-1 -> 0.
REQ-014 A clean victim SHALL be discarded. A dirty victim SHALL be latched into the writeback registers, the FSM SHALL enter WB, and the new line SHALL be written in the same cycle.
REQ-015 In WB, wb_valid_o SHALL be 1, and wb_addr_o/wb_data_o SHALL stay stable until the cycle wb_ready_i=1. The FSM SHALL then return to IDLE.
REQ-016 flush_i in IDLE SHALL start FLUSH. flush_i in WB SHALL be latched as pending and start FLUSH on WB completion.
REQ-017 FLUSH SHALL scan indices 0..NUM_ENTRIES-1 in order:
- each valid dirty entry is presented on wb and waits for wb_ready_i.
- other entries take one cycle each.
- every entry is invalidated after its index is processed.
- after the last index, flush_done_o pulses for 1 cycle and the FSM returns to IDLE.
REQ-018 When a take and an insert target the same address in the same cycle, the insert SHALL win: the entry stays valid with the new data.
REQ-019 LRU tracking SHALL use per-entry ages of $clog2(NUM_ENTRIES) bits:
- the accessed entry's age is set to 0.
- entries with a smaller age increment.
- the victim is the entry with age NUM_ENTRIES-1.
- invalidation does not modify ages.

Reset
REQ-020 rst=1 at a clock edge SHALL set the following, overriding every other input including a mid-WB or mid-FLUSH operation (any pending writeback is dropped):
- all valid and dirty bits = 0.
- FIFO pointer = 0.
- age[i] = i.
- state = IDLE.
- flush-pending = 0.
REQ-021 During and after reset, outputs SHALL be:
- wb_valid_o = 0, flush_done_o = 0, lkp_hit_o = 0.
- ins_ready_o = 1 from the first cycle after reset.

Structure
REQ-022 The state enum typedef vc_state_e and the default parameter constants SHALL live in the shared package cache_defs.
REQ-023 LRU age tracking SHALL be a sub-module victim_cache_repl, instantiated only when REPL_MODE=1.

Verification
REQ-024 Fill scenario: insert addresses 0x10..0x13, all clean, FIFO.
- all four then hit.
- inserting 0x14 evicts 0x10 with wb_valid_o=0.
- the pointer becomes 1.
REQ-025 Dirty eviction with backpressure: the victim is dirty and wb_ready_i is held 0 for 3 cycles.
- wb_valid_o=1 with stable addr/data for 4 cycles.
- ins_ready_o=0 throughout.
- return to IDLE after the ready cycle.
REQ-026 LRU scenario: insert 0x10..0x13, look up 0x10, then insert 0x20 -> 0x11 is evicted, not 0x10.
REQ-027 Take scenario: take-lookup 0x12 -> hit with the correct data. The next lookup of 0x12 misses, and the next insert reuses that index.
REQ-028 Flush scenario: entries 1 and 3 are dirty and flush_i is pulsed.
- exactly two wb transfers, in index order.
- flush_done_o is high for 1 cycle.
- all lookups then miss.
REQ-029 Reset mid-WB: assert rst while wb_valid_o=1.
- next cycle wb_valid_o=0 and all lookups miss.
- ins_ready_o=1 from the cycle after reset.
